// File: rtl/ps2_keycode_rx_pkg.sv
// Shared PS/2 definitions: scan-code constants used by the game logic and
// the receive FSM state encoding.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK    = 8'hF0;
  localparam logic [7:0] PS2_EXTENDED = 8'hE0;

  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_ESC   = 8'h76;
  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_A     = 8'h1C;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

endpackage

// File: rtl/ps2_keycode_rx_if.sv
// Keycode bus from the PS/2 receiver to the game-logic controllers.
interface ps2_keycode_rx_if;
  logic [15:0] keycode;
  logic        keycode_valid;
  logic        frame_err;

  modport master (output keycode, output keycode_valid, output frame_err);
  modport slave  (input  keycode, input  keycode_valid, input  frame_err);
endinterface

// File: rtl/ps2_keycode_rx_sync_filter.sv
// Brings the asynchronous PS/2 lines into the clk domain, debounces the
// PS/2 clock and emits a one-cycle strobe on each filtered falling edge.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_s,
  output logic fall_stb
);

  localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

  logic           clk_p0, clk_p1;
  logic           dat_p0, dat_p1;
  logic           filt;
  logic [CW-1:0]  cnt;

  // Two-flop synchronisers; idle bus level is high
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_p0 <= 1'b1;
      clk_p1 <= 1'b1;
      dat_p0 <= 1'b1;
      dat_p1 <= 1'b1;
    end else begin
      clk_p0 <= ps2_clk;
      clk_p1 <= clk_p0;
      dat_p0 <= ps2_data;
      dat_p1 <= dat_p0;
    end
  end

  // Glitch filter: level flips after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      filt     <= 1'b1;
      cnt      <= '0;
      fall_stb <= 1'b0;
    end else begin
      fall_stb <= 1'b0;
      if (clk_p1 == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt     <= clk_p1;
        cnt      <= '0;
        fall_stb <= filt;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign data_s = dat_p1;

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: deserialises device-to-host frames and presents
// the last two bytes as {previous, latest}. Odd-parity checking is enabled
// by defining PS2_PARITY_CHECK_EN; otherwise the parity bit is skipped.
module ps2_keycode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  ps2_keycode_rx_if.master kc
);
  import ps2_pkg::*;

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);

  function automatic logic parity_ok(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

  logic data_s, fall_stb;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync_filter (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .data_s  (data_s),
    .fall_stb(fall_stb)
  );

  rx_state_t       state, state_nx;
  logic [2:0]      bit_cnt, bit_cnt_nx;
  logic [7:0]      shift_reg, shift_nx;
  logic            par_bit, par_nx;
  logic [TO_W-1:0] to_cnt, to_nx;
  logic [15:0]     keycode_nx;
  logic            vld_nx, err_nx;
  logic            frame_ok;

  // State, datapath and registered output update
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      bit_cnt          <= '0;
      shift_reg        <= '0;
      par_bit          <= 1'b0;
      to_cnt           <= '0;
      kc.keycode       <= '0;
      kc.keycode_valid <= 1'b0;
      kc.frame_err     <= 1'b0;
    end else begin
      state            <= state_nx;
      bit_cnt          <= bit_cnt_nx;
      shift_reg        <= shift_nx;
      par_bit          <= par_nx;
      to_cnt           <= to_nx;
      kc.keycode       <= keycode_nx;
      kc.keycode_valid <= vld_nx;
      kc.frame_err     <= err_nx;
    end
  end

  // Frame FSM, timeout watchdog and keycode update
  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shift_nx   = shift_reg;
    par_nx     = par_bit;
    keycode_nx = kc.keycode;
    vld_nx     = 1'b0;
    err_nx     = 1'b0;
    frame_ok   = 1'b0;

    if (state == IDLE || fall_stb) to_nx = '0;
    else                           to_nx = to_cnt + 1'b1;

    case (state)
      IDLE: begin
        if (fall_stb && !data_s) begin
          state_nx   = DATA;
          bit_cnt_nx = '0;
        end
      end
      DATA: begin
        if (fall_stb) begin
          shift_nx   = {data_s, shift_reg[7:1]};
          bit_cnt_nx = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_nx = PARITY;
        end
      end
      PARITY: begin
        if (fall_stb) begin
          par_nx   = data_s;
          state_nx = STOP;
        end
      end
      STOP: begin
        if (fall_stb) begin
`ifdef PS2_PARITY_CHECK_EN
          frame_ok = data_s && parity_ok(shift_reg, par_bit);
`else
          frame_ok = data_s;
`endif
          if (frame_ok) begin
            keycode_nx = {kc.keycode[7:0], shift_reg};
            vld_nx     = 1'b1;
          end else begin
            err_nx = 1'b1;
          end
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    // A sample event in the same cycle wins over an expiring watchdog
    if (state != IDLE && !fall_stb && to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
      state_nx   = IDLE;
      bit_cnt_nx = '0;
      err_nx     = 1'b1;
      to_nx      = '0;
    end
  end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed bench for ps2_keycode_rx: frames are bit-banged on the PS/2 lines
// and pulse counts / keycode values are compared against hand-derived values.
module tb_ps2_keycode_rx;

  localparam int FILTER_LEN     = 4;
  localparam int TIMEOUT_CYCLES = 2000;
  localparam int HALF           = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_keycode_rx_if kc_if ();

  ps2_keycode_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .kc      (kc_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int vld_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int err_cyc = 0;
  int edge_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling clk edge
  always @(negedge clk) begin
    if (kc_if.keycode_valid) vld_cnt <= vld_cnt + 1;
    if (kc_if.frame_err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (kc_if.keycode_valid && kc_if.frame_err) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic d);
    ps2_data = d;
    repeat (HALF / 2) @(posedge clk);
    ps2_clk  = 1'b0;
    edge_cyc = cyc;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (HALF / 2) @(posedge clk);
  endtask

  // Full frame; bad_par inverts the correct odd-parity bit
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(stop);
    ps2_data = 1'b1;
    repeat (20) @(posedge clk);
  endtask

  int v0, e0, dly;

  initial begin
    repeat (5) @(posedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_keycode", 32'(kc_if.keycode), 32'h0000);
    check("rst_valid",   32'(kc_if.keycode_valid), 0);
    check("rst_err",     32'(kc_if.frame_err), 0);

    // 1: single good frame
    v0 = vld_cnt; e0 = err_cnt;
    send_frame(8'h5A, 1'b0, 1'b1);
    check("t1_vld", vld_cnt - v0, 1);
    check("t1_err", err_cnt - e0, 0);
    check("t1_kc",  32'(kc_if.keycode), 32'h005A);

    // 2: break sequence
    send_frame(8'hF0, 1'b0, 1'b1);
    check("t2_kc_f0", 32'(kc_if.keycode), 32'h5AF0);
    send_frame(8'h1C, 1'b0, 1'b1);
    check("t2_kc_f01c", 32'(kc_if.keycode), 32'hF01C);

    // 3: bad stop bit
    v0 = vld_cnt; e0 = err_cnt;
    send_frame(8'h5A, 1'b0, 1'b0);
    check("t3_vld", vld_cnt - v0, 0);
    check("t3_err", err_cnt - e0, 1);
    check("t3_kc",  32'(kc_if.keycode), 32'hF01C);

    send_frame(8'h1C, 1'b0, 1'b1);
    check("t2_kc_1c1c", 32'(kc_if.keycode), 32'h1C1C);

    // 4: wrong parity
    v0 = vld_cnt; e0 = err_cnt;
    send_frame(8'h29, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    check("t4_vld", vld_cnt - v0, 0);
    check("t4_err", err_cnt - e0, 1);
    check("t4_kc",  32'(kc_if.keycode), 32'h1C1C);
`else
    check("t4_vld", vld_cnt - v0, 1);
    check("t4_err", err_cnt - e0, 0);
    check("t4_kc",  32'(kc_if.keycode), 32'h1C29);
`endif

    // 5: truncated frame times out
    v0 = vld_cnt; e0 = err_cnt;
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    repeat (2500) @(posedge clk);
    check("t5_err", err_cnt - e0, 1);
    check("t5_vld", vld_cnt - v0, 0);
    dly = err_cyc - edge_cyc;
    check("t5_dly_lo", 32'(dly >= TIMEOUT_CYCLES), 1);
    check("t5_dly_hi", 32'(dly <= TIMEOUT_CYCLES + 20), 1);
    send_frame(8'h5A, 1'b0, 1'b1);
    check("t5_kc_lo", 32'(kc_if.keycode[7:0]), 32'h5A);

    // 6: clock glitches in idle are ignored
    v0 = vld_cnt; e0 = err_cnt;
    for (int g = 0; g < 3; g++) begin
      @(posedge clk); ps2_clk = 1'b0;
      repeat (2) @(posedge clk); ps2_clk = 1'b1;
      repeat (20) @(posedge clk);
    end
    check("t6_glitch_vld", vld_cnt - v0, 0);
    check("t6_glitch_err", err_cnt - e0, 0);

    // 6: reset after the 5th data bit discards the partial frame
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    rst = 1'b0;
    repeat (TIMEOUT_CYCLES + 100) @(posedge clk);
    check("t6_rst_vld", vld_cnt - v0, 0);
    check("t6_rst_err", err_cnt - e0, 0);
    check("t6_rst_kc",  32'(kc_if.keycode), 32'h0000);
    send_frame(8'h76, 1'b0, 1'b1);
    check("t6_kc", 32'(kc_if.keycode), 32'h0076);
    check("t6_vld", vld_cnt - v0, 1);

    check("never_both", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
